// File: rtl/fei4_emu_hit_source.sv
`default_nettype none
// ============================================================================
//  Module      : fei4_emu_hit_source
//  Description : Trigger-driven hit-data source for the FE-I4 emulator.
//                An accepted L1 trigger starts an event: after a programmable
//                latency one data header and n_hits pseudo-random data records
//                are written into an internal first-word-fall-through FIFO
//                that feeds the output serializer directly.
//  Ports       : clk, reset          - BC clock, synchronous active-high reset
//                enable, trigger_in  - trigger gating and L1 trigger pulse
//                bcr_in              - bunch-counter reset pulse
//                latency, n_hits     - per-event settings, sampled at trigger
//                read_fifo           - pop strobe from the serializer
//                data_word, empty,
//                full                - FIFO head word and status
//                busy, trig_dropped  - event in progress, rejected triggers
//  Revision    : 1.0 - initial release
// ============================================================================
module fei4_emu_hit_source #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter int          LAT_W     = 8,
    parameter int          HITS_W    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              trigger_in,
    input  logic              bcr_in,
    input  logic [LAT_W-1:0]  latency,
    input  logic [HITS_W-1:0] n_hits,
    input  logic              read_fifo,
    output logic [23:0]       data_word,
    output logic              empty,
    output logic              full,
    output logic              busy,
    output logic [7:0]        trig_dropped
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_wait  = 2'd1;
    localparam logic [1:0]  c_st_hdr   = 2'd2;
    localparam logic [1:0]  c_st_hits  = 2'd3;
    localparam logic [AW:0] c_full_cnt = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [LAT_W-1:0]  r_cnt;
    logic [HITS_W-1:0] r_hits_left;
    logic [7:0]        r_bcid;
    logic [7:0]        r_bcid_cap;
    logic [6:0]        r_lv1id;
    logic [6:0]        r_lv1id_cap;
    logic [15:0]       r_lfsr;
    logic [7:0]        r_trig_dropped;

    logic              w_trig_acc;
    logic              w_trig_drop;
    logic              w_wr_en;
    logic [23:0]       w_wr_data;
    logic              w_lfsr_adv;
    logic              w_lfsr_fb;

    // Record fields derived from the LFSR state before it advances
    logic [6:0]        w_col;
    logic [8:0]        w_row;
    logic [3:0]        w_tot1;

    // FIFO
    logic [23:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_rd_en;

    assign w_trig_acc  = trigger_in & enable & (r_state == c_st_idle);
    assign w_trig_drop = trigger_in & enable & (r_state != c_st_idle);

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    assign w_col  = {1'b0, r_lfsr[5:0]} + 7'd1;
    assign w_row  = {1'b0, r_lfsr[13:6]} + 9'd1;
    // 4'hF is reserved in the ToT field, so it folds onto 4'hE
    assign w_tot1 = (r_lfsr[3:0] == 4'hF) ? 4'hE : r_lfsr[3:0];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and FIFO write request
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_data   = 24'h0;
        w_lfsr_adv  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_trig_acc) begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_hdr;
                end
            end
            c_st_hdr: begin
                if (!full) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = {5'b11101, 3'b001, 1'b0, r_lv1id_cap, r_bcid_cap};
                    w_state_nxt = (r_hits_left != '0) ? c_st_hits : c_st_idle;
                end
            end
            c_st_hits: begin
                // Entered only with at least one record outstanding
                if (!full) begin
                    w_wr_en    = 1'b1;
                    w_wr_data  = {w_col, w_row, w_tot1, 4'hF};
                    w_lfsr_adv = 1'b1;
                    if (r_hits_left == HITS_W'(1)) begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters, captured event fields and LFSR
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_hits_left    <= '0;
            r_bcid         <= 8'd0;
            r_bcid_cap     <= 8'd0;
            r_lv1id        <= 7'd0;
            r_lv1id_cap    <= 7'd0;
            r_lfsr         <= LFSR_SEED;
            r_trig_dropped <= 8'd0;
        end else begin
            r_bcid <= bcr_in ? 8'd0 : r_bcid + 8'd1;

            if (w_trig_acc) begin
                r_bcid_cap  <= r_bcid;
                r_lv1id_cap <= r_lv1id;
                r_lv1id     <= r_lv1id + 7'd1;
                r_hits_left <= n_hits;
                r_cnt       <= latency;
            end else begin
                if (r_state == c_st_wait && r_cnt != '0) begin
                    r_cnt <= r_cnt - LAT_W'(1);
                end
                if (w_lfsr_adv) begin
                    r_hits_left <= r_hits_left - HITS_W'(1);
                end
            end

            if (w_lfsr_adv) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end

            if (w_trig_drop && r_trig_dropped != 8'hFF) begin
                r_trig_dropped <= r_trig_dropped + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO (first-word-fall-through). w_wr_en is already gated by !full,
    // so a read in the same cycle never lets a write through while full.
    // ------------------------------------------------------------------------
    assign w_rd_en = read_fifo & ~empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_full_cnt);
    assign data_word    = empty ? 24'h0 : r_mem[r_rptr];
    assign busy         = (r_state != c_st_idle);
    assign trig_dropped = r_trig_dropped;

endmodule
`default_nettype wire

// File: tb/tb_fei4_emu_hit_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fei4_emu_hit_source
//  Description : Directed self-checking bench for fei4_emu_hit_source.
//                A small reference model (bcid, lv1id, LFSR) fills a queue of
//                expected FIFO words that is compared against data_word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fei4_emu_hit_source;

    localparam logic [15:0] c_seed = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        trigger_in;
    logic        bcr_in;
    logic [7:0]  latency;
    logic [3:0]  n_hits;
    logic        read_fifo;
    logic [23:0] data_word;
    logic        empty;
    logic        full;
    logic        busy;
    logic [7:0]  trig_dropped;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  m_bcid;
    logic [6:0]  m_lv1id;
    logic [15:0] m_lfsr;
    logic [23:0] exp_q [$];

    fei4_emu_hit_source #(
        .DEPTH     (16),
        .AW        (4),
        .LAT_W     (8),
        .HITS_W    (4),
        .LFSR_SEED (c_seed)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trigger_in   (trigger_in),
        .bcr_in       (bcr_in),
        .latency      (latency),
        .n_hits       (n_hits),
        .read_fifo    (read_fifo),
        .data_word    (data_word),
        .empty        (empty),
        .full         (full),
        .busy         (busy),
        .trig_dropped (trig_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [23:0] mk_rec(input logic [15:0] l);
        logic [6:0] col;
        logic [8:0] row;
        logic [3:0] tot;
        col = {1'b0, l[5:0]} + 7'd1;
        row = {1'b0, l[13:6]} + 9'd1;
        tot = (l[3:0] == 4'hF) ? 4'hE : l[3:0];
        return {col, row, tot, 4'hF};
    endfunction

    function automatic logic [23:0] mk_hdr(input logic [6:0] lv1, input logic [7:0] bc);
        return {5'b11101, 3'b001, 1'b0, lv1, bc};
    endfunction

    // One clock edge; the bcid model follows the inputs applied to that edge
    task automatic tick();
        if (reset || bcr_in) m_bcid = 8'd0;
        else                 m_bcid = m_bcid + 8'd1;
        @(posedge clk);
        #1;
    endtask

    // Accepted trigger from IDLE: queue the expected header and records
    task automatic trig(input logic [7:0] lat, input logic [3:0] nh);
        latency    = lat;
        n_hits     = nh;
        trigger_in = 1'b1;
        exp_q.push_back(mk_hdr(m_lv1id, m_bcid));
        for (int i = 0; i < int'(nh); i++) begin
            exp_q.push_back(mk_rec(m_lfsr));
            m_lfsr = lfsr_next(m_lfsr);
        end
        m_lv1id = m_lv1id + 7'd1;
        tick();
        trigger_in = 1'b0;
    endtask

    task automatic pop();
        read_fifo = 1'b1;
        tick();
        read_fifo = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            if (!empty) begin
                check("drain_word", {8'd0, data_word}, {8'd0, exp_q.pop_front()});
                pop();
            end else begin
                tick();
            end
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        check("drain_empty", {31'd0, empty}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        trigger_in = 1'b0;
        bcr_in     = 1'b0;
        latency    = 8'd0;
        n_hits     = 4'd0;
        read_fifo  = 1'b0;
        m_bcid     = 8'd0;
        m_lv1id    = 7'd0;
        m_lfsr     = c_seed;

        repeat (3) tick();
        reset = 1'b0;
        check("rst_empty",   {31'd0, empty}, 32'd1);
        check("rst_full",    {31'd0, full},  32'd0);
        check("rst_data",    {8'd0, data_word}, 32'd0);
        check("rst_busy",    {31'd0, busy},  32'd0);
        check("rst_dropped", {24'd0, trig_dropped}, 32'd0);

        // ---- T1: latency 3, two records, trigger at bcid 0x10 ----
        bcr_in = 1'b1;
        tick();
        bcr_in = 1'b0;
        repeat (16) tick();
        trig(8'd3, 4'd2);                       // edge t
        repeat (4) tick();                      // t+4
        check("t1_empty_before", {31'd0, empty}, 32'd1);
        tick();                                 // t+5: header written
        check("t1_empty_after", {31'd0, empty}, 32'd0);
        check("t1_header", {8'd0, data_word}, 32'h00E90010);
        check("t1_busy", {31'd0, busy}, 32'd1);
        repeat (2) tick();                      // t+7: last record written
        check("t1_idle", {31'd0, busy}, 32'd0);
        pop();
        check("t1_rec1", {8'd0, data_word}, 32'h0044B41F);
        pop();
        check("t1_rec2", {8'd0, data_word}, {8'd0, mk_rec(lfsr_next(c_seed))});
        pop();
        check("t1_drained", {31'd0, empty}, 32'd1);
        exp_q.delete();

        // ---- T2: lv1id sequence and wrap ----
        for (int i = 0; i < 3; i++) begin
            trig(8'd0, 4'd0);
            wait_idle(20);
        end
        check("t2_lv1id0", {25'd0, data_word[14:8]}, 32'd1);
        drain();
        read_fifo = 1'b1;
        for (int i = 0; i < 200 && m_lv1id != 7'd127; i++) begin
            trig(8'd0, 4'd0);
            tick();
            tick();
        end
        tick();
        read_fifo = 1'b0;
        exp_q.delete();
        check("t2_bump_empty", {31'd0, empty}, 32'd1);
        trig(8'd0, 4'd0);
        wait_idle(20);
        trig(8'd0, 4'd0);
        wait_idle(20);
        check("t2_lv1id127", {25'd0, data_word[14:8]}, 32'd127);
        drain();

        // ---- T3: FIFO full, stall in HITS, resume after one pop ----
        trig(8'd0, 4'd2);
        wait_idle(20);
        trig(8'd0, 4'd15);
        for (int i = 0; i < 40 && !full; i++) tick();
        check("t3_full", {31'd0, full}, 32'd1);
        repeat (3) tick();
        check("t3_stall_full", {31'd0, full}, 32'd1);
        check("t3_stall_busy", {31'd0, busy}, 32'd1);
        check("t3_head", {8'd0, data_word}, {8'd0, exp_q.pop_front()});
        pop();
        check("t3_pop_frees", {31'd0, full}, 32'd0);
        tick();
        check("t3_refill", {31'd0, full}, 32'd1);
        drain();
        check("t3_idle", {31'd0, busy}, 32'd0);

        // ---- T4: dropped triggers saturate, lv1id untouched ----
        latency    = 8'd255;
        n_hits     = 4'd0;
        trigger_in = 1'b1;
        exp_q.push_back(mk_hdr(m_lv1id, m_bcid));
        m_lv1id = m_lv1id + 7'd1;
        tick();                                 // accepted
        repeat (254) tick();                    // all dropped
        trigger_in = 1'b0;
        check("t4_dropped_254", {24'd0, trig_dropped}, 32'd254);
        wait_idle(50);
        drain();
        trig(8'd40, 4'd0);
        trigger_in = 1'b1;
        repeat (5) tick();
        trigger_in = 1'b0;
        check("t4_dropped_sat", {24'd0, trig_dropped}, 32'hFF);
        wait_idle(60);
        drain();
        enable     = 1'b0;
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        check("t4_disabled_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        trig(8'd2, 4'd3);
        enable = 1'b0;                          // event still completes
        wait_idle(30);
        drain();
        enable = 1'b1;

        // ---- T5: bcr at bcid 255, reset mid-HITS ----
        for (int i = 0; i < 300 && m_bcid != 8'd255; i++) tick();
        bcr_in = 1'b1;
        tick();
        bcr_in = 1'b0;
        trig(8'd0, 4'd0);
        wait_idle(20);
        check("t5_bcr_wins", {24'd0, data_word[7:0]}, 32'd0);
        drain();
        trig(8'd0, 4'd10);
        repeat (5) tick();
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_empty",   {31'd0, empty}, 32'd1);
        check("t5_rst_busy",    {31'd0, busy},  32'd0);
        check("t5_rst_data",    {8'd0, data_word}, 32'd0);
        check("t5_rst_dropped", {24'd0, trig_dropped}, 32'd0);
        exp_q.delete();
        m_lfsr  = c_seed;
        m_lv1id = 7'd0;
        trig(8'd0, 4'd1);
        wait_idle(20);
        pop();
        check("t5_seed_rec", {8'd0, data_word}, 32'h0044B41F);
        exp_q.delete();
        pop();

        // ---- T6: reads while empty, simultaneous read and write ----
        read_fifo = 1'b1;
        repeat (3) tick();
        check("t6_underflow_empty", {31'd0, empty}, 32'd1);
        check("t6_underflow_data", {8'd0, data_word}, 32'd0);
        trig(8'd0, 4'd6);                       // edge t
        tick();                                 // t+1
        tick();                                 // t+2: header written
        for (int i = 0; i < 7; i++) begin
            check("t6_rw_word", {8'd0, data_word}, {8'd0, exp_q.pop_front()});
            check("t6_rw_nonempty", {31'd0, empty}, 32'd0);
            tick();
        end
        read_fifo = 1'b0;
        check("t6_final_empty", {31'd0, empty}, 32'd1);
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
